bus_cycle_ctrl: RTL and testbench

Synchronous 68000 bus-cycle sequencer for the glue CPLD.
- Per /AS cycle: decodes the address and drives the ROM/RAM/DUART byte chip selects.
- Inserts per-region wait states, then generates /DTACK, or passes through the DUART's own DTACK.
- Raises /BERR when a cycle is never acknowledged.
- Implements the boot overlay: the first 8 bus cycles after reset go to ROM regardless of address.

---
 rtl/bus_cycle_ctrl_if.sv | 41 ++++
 rtl/bus_cycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_ctrl_if.sv
// 68000 bus-side signals of the glue CPLD sequencer.
// master = CPU/DUART side, slave = bus_cycle_ctrl.
interface bus_cycle_ctrl_if;
  logic as;
  logic uds;
  logic lds;
  logic a7;
  logic a8;
  logic a9;
  logic a17;
  logic a21;
  logic duart_dtack;
  logic rom_evn_cs;
  logic rom_odd_cs;
  logic ram_evn_cs;
  logic ram_odd_cs;
  logic duart_cs;
  logic dtack;
  logic berr;
  logic boot_overlay;

  modport master (
    output as, uds, lds,
    output a7, a8, a9, a17, a21,
    output duart_dtack,
    input  rom_evn_cs, rom_odd_cs,
    input  ram_evn_cs, ram_odd_cs,
    input  duart_cs, dtack, berr,
    input  boot_overlay
  );

  modport slave (
    input  as, uds, lds,
    input  a7, a8, a9, a17, a21,
    input  duart_dtack,
    output rom_evn_cs, rom_odd_cs,
    output ram_evn_cs, ram_odd_cs,
    output duart_cs, dtack, berr,
    output boot_overlay
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: decode, wait states, DTACK, boot overlay.
// Define BERR_WATCHDOG_EN to build the /BERR watchdog.
module bus_cycle_ctrl #(
  parameter int ROM_WS         = 2,
  parameter int RAM_WS         = 0,
  parameter int BERR_CYCLES    = 64,
  parameter int OVERLAY_CYCLES = 8
) (
  input logic             clk_in,
  input logic             reset,
  bus_cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_ST,
    DUART_WAIT,
    ACK,
    BERR_ST
  } state_t;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_DUART,
    RG_UNMAP
  } region_t;

  localparam logic [3:0] OVL   = 4'(OVERLAY_CYCLES);
  localparam logic [3:0] ROM_W = 4'(ROM_WS);
  localparam logic [3:0] RAM_W = 4'(RAM_WS);

  if (ROM_WS < 0 || ROM_WS > 15 ||
      RAM_WS < 0 || RAM_WS > 15 ||
      BERR_CYCLES < 2 || BERR_CYCLES > 255 ||
      OVERLAY_CYCLES < 0 || OVERLAY_CYCLES > 15)
  begin : g_param_err
    $error("bus_cycle_ctrl: parameter out of range");
  end

  state_t     state;
  region_t    region;
  region_t    dec_region;
  logic [3:0] cnt;
  logic [3:0] ovl_cnt;
  logic [4:0] cs;
  logic       dtack_q;
  logic       berr_q;
  logic       duart_q;
  logic       overlay;
  logic       ack_now;
  logic       wd_hit;

  assign overlay = ovl_cnt < OVL;

  always_comb begin
    dec_region = RG_UNMAP;
    unique case (1'b1)
      overlay:
        dec_region = RG_ROM;
      !overlay && !bus.a21:
        dec_region = RG_RAM;
      !overlay && bus.a21 && !bus.a17:
        dec_region = RG_ROM;
      !overlay && bus.a21 && bus.a17 &&
      ({bus.a9, bus.a8, bus.a7} == 3'b000):
        dec_region = RG_DUART;
      default:
        dec_region = RG_UNMAP;
    endcase
  end

  // {rom_evn, rom_odd, ram_evn, ram_odd, duart}
  function automatic logic [4:0] sel_of(
    region_t r, logic u, logic l
  );
    case (r)
      RG_ROM:   sel_of = {u, l, 3'b111};
      RG_RAM:   sel_of = {2'b11, u, l, 1'b1};
      RG_DUART: sel_of = {4'b1111, u & l};
      default:  sel_of = 5'b11111;
    endcase
  endfunction

  always_comb begin
    ack_now = 1'b0;
    unique case (state)
      DECODE:
        ack_now = (region == RG_ROM && ROM_W == 4'd0) ||
                  (region == RG_RAM && RAM_W == 4'd0);
      WAIT_ST:
        ack_now = region != RG_UNMAP && cnt == 4'd0;
      DUART_WAIT:
        ack_now = !duart_q;
      default:
        ack_now = 1'b0;
    endcase
  end

`ifdef BERR_WATCHDOG_EN
  logic [7:0] wd;

  assign wd_hit = wd == 8'(BERR_CYCLES - 1);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)
      wd <= '0;
    else if (state == IDLE)
      wd <= '0;
    else if (state inside {DECODE, WAIT_ST, DUART_WAIT})
      wd <= wd + 8'd1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      region  <= RG_UNMAP;
      cnt     <= '0;
      ovl_cnt <= '0;
      cs      <= '1;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      duart_q <= 1'b1;
    end else begin
      duart_q <= bus.duart_dtack;
      if (bus.as) begin
        state   <= IDLE;
        cs      <= '1;
        dtack_q <= 1'b1;
        berr_q  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= DECODE;
            region <= dec_region;
            cs     <= sel_of(dec_region, bus.uds, bus.lds);
            if (overlay)
              ovl_cnt <= ovl_cnt + 4'd1;
          end
          DECODE, WAIT_ST, DUART_WAIT: begin
            if (ack_now) begin
              state   <= ACK;
              dtack_q <= 1'b0;
              cs      <= sel_of(region, bus.uds, bus.lds);
            end else if (wd_hit) begin
              state  <= BERR_ST;
              berr_q <= 1'b0;
              cs     <= '1;
            end else begin
              cs <= sel_of(region, bus.uds, bus.lds);
              if (state == DECODE) begin
                state <= (region == RG_DUART) ? DUART_WAIT
                                              : WAIT_ST;
                // unmapped cycles keep cnt and never expire
                if (region == RG_ROM)
                  cnt <= ROM_W - 4'd1;
                else if (region == RG_RAM)
                  cnt <= RAM_W - 4'd1;
              end else if (state == WAIT_ST &&
                           region != RG_UNMAP) begin
                cnt <= cnt - 4'd1;
              end
            end
          end
          ACK:
            cs <= sel_of(region, bus.uds, bus.lds);
          default: ;
        endcase
      end
    end
  end

  assign bus.rom_evn_cs   = cs[4];
  assign bus.rom_odd_cs   = cs[3];
  assign bus.ram_evn_cs   = cs[2];
  assign bus.ram_odd_cs   = cs[1];
  assign bus.duart_cs     = cs[0];
  assign bus.dtack        = dtack_q;
  assign bus.berr         = berr_q;
  assign bus.boot_overlay = overlay;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: driver pushes expected cycle
// outcomes, a monitor pops them when it sees each /AS cycle end.
module tb_bus_cycle_ctrl;

  localparam int ROM_WS         = 2;
  localparam int RAM_WS         = 0;
  localparam int BERR_CYCLES    = 64;
  localparam int OVERLAY_CYCLES = 8;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_BERR = 2;

  localparam int R_ROM   = 0;
  localparam int R_RAM   = 1;
  localparam int R_DUART = 2;
  localparam int R_UNMAP = 3;

  localparam int NEVER = 1000000;

  typedef struct {
    int         kind;
    int         n;
    logic [4:0] cs0;
    logic [4:0] csr;
    logic       bo;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset;
  bit   mon_en;
  int   n_cmp;
  int   n_bad;
  int   ovl_model;
  exp_t q[$];

  bus_cycle_ctrl_if bus ();

  bus_cycle_ctrl #(
    .ROM_WS         (ROM_WS),
    .RAM_WS         (RAM_WS),
    .BERR_CYCLES    (BERR_CYCLES),
    .OVERLAY_CYCLES (OVERLAY_CYCLES)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] cs_obs();
    return {bus.rom_evn_cs, bus.rom_odd_cs,
            bus.ram_evn_cs, bus.ram_odd_cs, bus.duart_cs};
  endfunction

  function automatic logic [6:0] outs();
    return {cs_obs(), bus.dtack, bus.berr};
  endfunction

  function automatic int region_of(input bit ovl, input bit a21,
                                   input bit a17, input bit a9,
                                   input bit a8, input bit a7);
    if (ovl) return R_ROM;
    if (!a21) return R_RAM;
    if (!a17) return R_ROM;
    if (!a9 && !a8 && !a7) return R_DUART;
    return R_UNMAP;
  endfunction

  function automatic logic [4:0] sel_of(input int r, input bit u,
                                        input bit l);
    logic [4:0] v;
    v = 5'b11111;
    if (r == R_ROM) begin
      v[4] = u;
      v[3] = l;
    end else if (r == R_RAM) begin
      v[2] = u;
      v[1] = l;
    end else if (r == R_DUART) begin
      v[0] = u & l;
    end
    return v;
  endfunction

  // Response edge from the cycle rules: WS-derived or DUART-derived
  // acknowledge, capped by the watchdog when it is built in.
  task automatic resp_of(input int r, input int dl,
                         output int kind, output int n);
    int ack_n;
    ack_n = NEVER;
    if (r == R_ROM) ack_n = 1 + ROM_WS;
    else if (r == R_RAM) ack_n = 1 + RAM_WS;
    else if (r == R_DUART && dl >= 0)
      ack_n = (dl + 1 > 2) ? dl + 1 : 2;
    kind = K_ACK;
    n = ack_n;
`ifdef BERR_WATCHDOG_EN
    if (ack_n > BERR_CYCLES) begin
      kind = K_BERR;
      n = BERR_CYCLES;
    end
`endif
    if (n == NEVER) kind = K_NONE;
  endtask

  // hold: edges /AS stays sampled low; -1 = until response, -2 = abort
  task automatic run_cycle(input bit a21, input bit a17,
                           input bit a9, input bit a8, input bit a7,
                           input bit u, input bit l,
                           input int dl, input int hold);
    exp_t x;
    int r;
    int h;
    x.bo = (ovl_model < OVERLAY_CYCLES);
    r = region_of(x.bo, a21, a17, a9, a8, a7);
    if (x.bo) ovl_model++;
    resp_of(r, dl, x.kind, x.n);
    h = hold;
    if (h < 0 && x.kind == K_NONE) h = 20;
    else if (h == -1) h = x.n + 1 + int'($urandom_range(0, 2));
    else if (h == -2) h = int'($urandom_range(1, x.n));
    if (x.kind != K_NONE && x.n >= h) x.kind = K_NONE;
    if (x.kind == K_NONE) x.n = -1;
    x.cs0 = sel_of(r, u, l);
    x.csr = (x.kind == K_BERR) ? 5'b11111 : x.cs0;
    q.push_back(x);
    @(negedge clk_in);
    bus.a21 = a21;
    bus.a17 = a17;
    bus.a9 = a9;
    bus.a8 = a8;
    bus.a7 = a7;
    bus.uds = u;
    bus.lds = l;
    bus.duart_dtack = (dl == 0) ? 1'b0 : 1'b1;
    bus.as = 1'b0;
    for (int e = 0; e < h; e++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (dl == e + 1) bus.duart_dtack = 1'b0;
    end
    bus.as = 1'b1;
    @(negedge clk_in);
    bus.duart_dtack = 1'b1;
    bus.uds = 1'b1;
    bus.lds = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin : monitor
    logic       as_s;
    bit         active;
    int         e;
    int         fr;
    int         fk;
    logic [4:0] cs0;
    logic [4:0] csr;
    logic       bo_idle;
    logic       bo_pre;
    exp_t       x;
    active = 0;
    e = 0;
    fr = -1;
    fk = K_NONE;
    cs0 = '1;
    csr = '1;
    bo_idle = 1'b1;
    bo_pre = 1'b1;
    forever begin
      @(posedge clk_in);
      as_s = bus.as;
      @(negedge clk_in);
      if (!mon_en) begin
        active = 0;
      end else if (!as_s) begin
        if (!active) begin
          active = 1;
          e = 0;
          fr = -1;
          fk = K_NONE;
          cs0 = cs_obs();
          csr = '1;
          bo_pre = bo_idle;
        end else begin
          e++;
        end
        if (fk == K_NONE && !bus.dtack) begin
          fk = K_ACK;
          fr = e;
          csr = cs_obs();
        end else if (fk == K_NONE && !bus.berr) begin
          fk = K_BERR;
          fr = e;
          csr = cs_obs();
        end
      end else begin
        if (active) begin
          active = 0;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got cycle end expected none");
          end else begin
            x = q.pop_front();
            chk("boot_overlay", 32'(bo_pre), 32'(x.bo));
            chk("resp_kind", fk, x.kind);
            chk("resp_edge", fr, x.n);
            chk("cs_after_e0", 32'(cs0), 32'(x.cs0));
            if (x.kind != K_NONE)
              chk("cs_at_resp", 32'(csr), 32'(x.csr));
            chk("release", 32'(outs()), 32'h7f);
          end
        end
        bo_idle = bus.boot_overlay;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   cat;
    int   dl;
    int   r;
    bit   ovl;
    logic [2:0] ah;
    n_cmp = 0;
    n_bad = 0;
    mon_en = 0;
    ovl_model = 0;
    reset = 1'b0;
    bus.as = 1'b1;
    bus.uds = 1'b1;
    bus.lds = 1'b1;
    bus.a7 = 1'b0;
    bus.a8 = 1'b0;
    bus.a9 = 1'b0;
    bus.a17 = 1'b0;
    bus.a21 = 1'b0;
    bus.duart_dtack = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("reset_outs", 32'(outs()), 32'h7f);
    chk("reset_overlay", 32'(bus.boot_overlay),
        32'(OVERLAY_CYCLES > 0));
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    mon_en = 1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 10; i++)
      run_cycle(1, 1, 1, 1, 1, 0, 0, -1, -1);
    run_cycle(0, 1, 0, 1, 0, 0, 1, -1, -1);
    run_cycle(1, 1, 0, 0, 0, 0, 0, 5, -1);
`ifdef BERR_WATCHDOG_EN
    run_cycle(1, 1, 0, 0, 0, 0, 0, -1, -1);
`else
    run_cycle(1, 1, 0, 0, 0, 0, 0, -1, 200);
`endif
    run_cycle(1, 0, 0, 0, 0, 0, 0, -1, 2);

    for (int i = 0; i < 40; i++) begin
      cat = int'($urandom_range(0, 3));
      dl = int'($urandom_range(0, 8));
      ah = 3'($urandom_range(1, 7));
      if (cat == 0)
        run_cycle(0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), dl,
                  ($urandom_range(0, 4) == 0) ? -2 : -1);
      else if (cat == 1)
        run_cycle(1, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), dl,
                  ($urandom_range(0, 4) == 0) ? -2 : -1);
      else if (cat == 2)
        run_cycle(1, 1, 0, 0, 0, 1'($urandom), 1'($urandom), dl,
                  ($urandom_range(0, 4) == 0) ? -2 : -1);
      else
        run_cycle(1, 1, ah[2], ah[1], ah[0], 1'($urandom),
                  1'($urandom), dl, -1);
    end

    // async reset in the middle of a ROM wait
    mon_en = 0;
    @(negedge clk_in);
    ovl = (ovl_model < OVERLAY_CYCLES);
    r = region_of(ovl, 1, 0, 0, 0, 0);
    bus.a21 = 1'b1;
    bus.a17 = 1'b0;
    bus.uds = 1'b0;
    bus.lds = 1'b0;
    bus.as = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("pre_reset_cs", 32'(cs_obs()), 32'(sel_of(r, 0, 0)));
    chk("pre_reset_dtack", 32'(bus.dtack), 32'h1);
    reset = 1'b0;
    #1;
    chk("reset_async_outs", 32'(outs()), 32'h7f);
    chk("reset_async_overlay", 32'(bus.boot_overlay),
        32'(OVERLAY_CYCLES > 0));
    ovl_model = 0;
    bus.as = 1'b1;
    bus.uds = 1'b1;
    bus.lds = 1'b1;
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    mon_en = 1;
    repeat (2) @(negedge clk_in);
    run_cycle(0, 0, 0, 0, 0, 0, 0, -1, -1);
    run_cycle(0, 1, 1, 0, 1, 1, 0, -1, -1);

    repeat (4) @(negedge clk_in);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
